seq_array_mult: RTL

//  Parametrised sequential multiplier for WIDTH x WIDTH operands.

---
 rtl/seq_array_mult_if.sv | 24 ++
 rtl/seq_array_mult.sv | 86 ++++++++
 2 files changed

// File: rtl/seq_array_mult_if.sv
// rtl/seq_array_mult_if.sv - operand/product handshake bundle for seq_array_mult
interface seq_array_mult_if #(
  parameter int WIDTH = 4
);
  logic               in_valid;
  logic               in_ready;
  logic               in_signed;
  logic [WIDTH-1:0]   in_m;
  logic [WIDTH-1:0]   in_q;
  logic               out_valid;
  logic               out_ready;
  logic [2*WIDTH-1:0] out_p;
  logic               busy;

  modport slave (
    input  in_valid, in_signed, in_m, in_q, out_ready,
    output in_ready, out_valid, out_p, busy
  );

  modport master (
    output in_valid, in_signed, in_m, in_q, out_ready,
    input  in_ready, out_valid, out_p, busy
  );
endinterface

// File: rtl/seq_array_mult.sv
// rtl/seq_array_mult.sv - radix-2 shift-add sequential multiplier, one partial-product row per cycle
// Signed operands are multiplied as magnitudes; the sign is reapplied in FIX.
module seq_array_mult #(
  parameter int WIDTH     = 4,
  parameter bit SIGNED_EN = 1'b1
) (
  input  logic           clk,
  input  logic           rst,
  seq_array_mult_if.slave bus
);
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, BUSY, FIX, DONE} state_t;

  state_t             state, state_n;
  logic [WIDTH-1:0]   mcand, mult;
  logic [2*WIDTH:0]   acc, acc_add;
  logic [CW-1:0]      cnt;
  logic               neg;
  logic [2*WIDTH-1:0] prod;
  logic               use_signed, last_iter;
  logic [WIDTH-1:0]   m_abs, q_abs;

  always_comb begin
    use_signed = SIGNED_EN && bus.in_signed;
    // |-2^(WIDTH-1)| wraps back to the same bit pattern, which is correct read as unsigned
    m_abs = (use_signed && bus.in_m[WIDTH-1]) ? (~bus.in_m + WIDTH'(1)) : bus.in_m;
    q_abs = (use_signed && bus.in_q[WIDTH-1]) ? (~bus.in_q + WIDTH'(1)) : bus.in_q;
    acc_add   = mult[0] ? (acc + {1'b0, mcand, {WIDTH{1'b0}}}) : acc;
    last_iter = (cnt == CW'(WIDTH - 1));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE: if (bus.in_valid) state_n = BUSY;
      BUSY: if (last_iter) state_n = FIX;
      FIX:  state_n = DONE;
      DONE: if (bus.out_ready) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mcand <= '0;
      mult  <= '0;
      acc   <= '0;
      cnt   <= '0;
      neg   <= 1'b0;
      prod  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            mcand <= m_abs;
            mult  <= q_abs;
            acc   <= '0;
            cnt   <= '0;
            neg   <= use_signed && (bus.in_m[WIDTH-1] ^ bus.in_q[WIDTH-1]);
          end
        end
        BUSY: begin
          acc  <= acc_add >> 1;
          mult <= mult >> 1;
          cnt  <= cnt + CW'(1);
        end
        FIX: prod <= neg ? -acc[2*WIDTH-1:0] : acc[2*WIDTH-1:0];
        default: ;
      endcase
    end
  end

  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = (state == DONE);
  assign bus.busy      = (state == BUSY) || (state == FIX);
  assign bus.out_p     = prod;
endmodule
